e_iter_alu: RTL and testbench

E_ITER_ALU -- requirements
Module: e_iter_alu

---
 rtl/e_iter_alu_pkg.sv | 44 ++++
 rtl/e_iter_alu_md_core.sv | 55 +++++
 rtl/e_iter_alu.sv | 159 +++++++++++++++
 tb/tb_e_iter_alu.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/e_iter_alu_pkg.sv
// Shared constants for the E-stage iterative ALU: opcodes, FSM state
// encodings, the overflow exception code and opcode-class helpers.
package e_iter_alu_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned ST_W  = 2;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned EXC_W = 5;

  localparam logic [OP_W-1:0] OP_ADDU  = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD   = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd2;
  localparam logic [OP_W-1:0] OP_OR    = 4'd3;
  localparam logic [OP_W-1:0] OP_AND   = 4'd4;
  localparam logic [OP_W-1:0] OP_SLT   = 4'd5;
  localparam logic [OP_W-1:0] OP_SLTU  = 4'd6;
  localparam logic [OP_W-1:0] OP_MFHI  = 4'd7;
  localparam logic [OP_W-1:0] OP_MFLO  = 4'd8;
  localparam logic [OP_W-1:0] OP_MTHI  = 4'd9;
  localparam logic [OP_W-1:0] OP_MTLO  = 4'd10;
  localparam logic [OP_W-1:0] OP_MULT  = 4'd11;
  localparam logic [OP_W-1:0] OP_MULTU = 4'd12;
  localparam logic [OP_W-1:0] OP_DIV   = 4'd13;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'd14;
  localparam logic [OP_W-1:0] OP_NOP   = 4'd15;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_MUL  = 2'd1;
  localparam logic [ST_W-1:0] ST_DIV  = 2'd2;

  localparam logic [EXC_W-1:0] EXC_OV   = 5'b01100;
  localparam logic [EXC_W-1:0] EXC_NONE = 5'b00000;

  // Ops that touch HI/LO or the mult/div unit (MTHI..DIVU)
  function automatic logic is_md_op(input logic [OP_W-1:0] op);
    return (op >= OP_MTHI) && (op <= OP_DIVU);
  endfunction

  // Ops that must wait while a mult/div is in flight (MFHI..DIVU)
  function automatic logic is_hilo_op(input logic [OP_W-1:0] op);
    return (op >= OP_MFHI) && (op <= OP_DIVU);
  endfunction

endpackage

// File: rtl/e_iter_alu_md_core.sv
// Multiply/divide datapath. Purely combinational on the latched operands;
// the owning FSM decides when the result is committed to HI/LO.
//   i_a, i_b      latched operands
//   i_signed      signed (MULT/DIV) vs unsigned (MULTU/DIVU)
//   i_div         1 = divide, 0 = multiply
//   o_hi, o_lo    result (remainder/quotient or product high/low)
//   o_div_zero    divide with zero divisor: result must not be committed
module e_md_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_signed,
  input  logic             i_div,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_div_zero
);

  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_a_neg;
  logic               w_b_neg;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_b_safe;
  logic [WIDTH-1:0]   w_q_mag;
  logic [WIDTH-1:0]   w_r_mag;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;

  // Full-width product: sign/zero extend to 2*WIDTH, keep low 2*WIDTH bits
  assign w_a_ext = i_signed ? {{WIDTH{i_a[WIDTH-1]}}, i_a} : {{WIDTH{1'b0}}, i_a};
  assign w_b_ext = i_signed ? {{WIDTH{i_b[WIDTH-1]}}, i_b} : {{WIDTH{1'b0}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Sign-magnitude divide; most-negative magnitude fits as unsigned
  assign w_a_neg  = i_signed & i_a[WIDTH-1];
  assign w_b_neg  = i_signed & i_b[WIDTH-1];
  assign w_b_zero = (i_b == '0);
  assign w_a_mag  = w_a_neg ? -i_a : i_a;
  assign w_b_mag  = w_b_neg ? -i_b : i_b;
  assign w_b_safe = w_b_zero ? WIDTH'(1) : w_b_mag;
  assign w_q_mag  = w_a_mag / w_b_safe;
  assign w_r_mag  = w_a_mag % w_b_safe;
  assign w_q      = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
  assign w_r      = w_a_neg ? -w_r_mag : w_r_mag;

  assign o_hi       = i_div ? w_r : w_prod[2*WIDTH-1:WIDTH];
  assign o_lo       = i_div ? w_q : w_prod[WIDTH-1:0];
  assign o_div_zero = i_div & w_b_zero;

endmodule

// File: rtl/e_iter_alu.sv
// E-stage ALU: single-cycle integer ops plus a fixed-latency multi-cycle
// multiply/divide unit owning the architectural HI/LO registers.
//   clk, reset     clock, synchronous active-high reset
//   E_ALUA/E_ALUB  operands; E_ALUControl opcode; E_Start valid; E_Flush cancel
//   E_ALURe        combinational result; Cur_E_ExcCode overflow code
//   E_Stall        hold E while an HI/LO op waits on a busy unit
//   E_Busy         mult/div in flight; E_HI/E_LO architectural HI/LO
module e_iter_alu
  import e_iter_alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] E_ALUA,
  input  logic [WIDTH-1:0] E_ALUB,
  input  logic [3:0]       E_ALUControl,
  input  logic             E_Start,
  input  logic             E_Flush,
  output logic [WIDTH-1:0] E_ALURe,
  output logic             E_Stall,
  output logic             E_Busy,
  output logic [4:0]       Cur_E_ExcCode,
  output logic [WIDTH-1:0] E_HI,
  output logic [WIDTH-1:0] E_LO
);

  logic [ST_W-1:0]  r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_hi, w_hi_nxt;
  logic [WIDTH-1:0] r_lo, w_lo_nxt;
  logic [WIDTH-1:0] r_op_a, w_op_a_nxt;
  logic [WIDTH-1:0] r_op_b, w_op_b_nxt;
  logic             r_signed, w_signed_nxt;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic             w_ov;
  logic             w_slt;
  logic             w_sltu;
  logic             w_live;
  logic             w_accept;
  logic [WIDTH-1:0] w_md_hi;
  logic [WIDTH-1:0] w_md_lo;
  logic             w_md_div0;

  e_md_core #(.WIDTH(WIDTH)) u_md_core (
    .i_a        (r_op_a),
    .i_b        (r_op_b),
    .i_signed   (r_signed),
    .i_div      (r_state == ST_DIV),
    .o_hi       (w_md_hi),
    .o_lo       (w_md_lo),
    .o_div_zero (w_md_div0)
  );

  // Single-cycle ALU; overflow from a sign-extended WIDTH+1 bit sum
  assign w_sum  = {E_ALUA[WIDTH-1], E_ALUA} + {E_ALUB[WIDTH-1], E_ALUB};
  assign w_dif  = {E_ALUA[WIDTH-1], E_ALUA} - {E_ALUB[WIDTH-1], E_ALUB};
  assign w_slt  = $signed(E_ALUA) < $signed(E_ALUB);
  assign w_sltu = E_ALUA < E_ALUB;
  assign w_ov   = ((E_ALUControl == OP_ADD) && (w_sum[WIDTH] != w_sum[WIDTH-1])) ||
                  ((E_ALUControl == OP_SUB) && (w_dif[WIDTH] != w_dif[WIDTH-1]));

  always_comb begin
    E_ALURe = '0;
    case (E_ALUControl)
      OP_ADDU, OP_ADD: E_ALURe = w_sum[WIDTH-1:0];
      OP_SUB:          E_ALURe = w_dif[WIDTH-1:0];
      OP_OR:           E_ALURe = E_ALUA | E_ALUB;
      OP_AND:          E_ALURe = E_ALUA & E_ALUB;
      OP_SLT:          E_ALURe = {{(WIDTH-1){1'b0}}, w_slt};
      OP_SLTU:         E_ALURe = {{(WIDTH-1){1'b0}}, w_sltu};
      OP_MFHI:         E_ALURe = r_hi;
      OP_MFLO:         E_ALURe = r_lo;
      default:         E_ALURe = '0;
    endcase
  end

  assign w_live        = E_Start & ~E_Flush;
  assign Cur_E_ExcCode = (w_live && w_ov) ? EXC_OV : EXC_NONE;
  assign E_Busy        = (r_state != ST_IDLE);
  assign E_Stall       = w_live & E_Busy & is_hilo_op(E_ALUControl);
  assign w_accept      = w_live & ~E_Busy & is_md_op(E_ALUControl) &
                         (Cur_E_ExcCode == EXC_NONE);
  assign E_HI          = r_hi;
  assign E_LO          = r_lo;

  // Next-state: accept in IDLE, count down while busy, commit at zero
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_op_a_nxt   = r_op_a;
    w_op_b_nxt   = r_op_b;
    w_signed_nxt = r_signed;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (E_ALUControl)
            OP_MTHI: w_hi_nxt = E_ALUA;
            OP_MTLO: w_lo_nxt = E_ALUA;
            OP_MULT, OP_MULTU: begin
              w_state_nxt  = ST_MUL;
              w_cnt_nxt    = CNT_W'(MUL_LAT - 1);
              w_op_a_nxt   = E_ALUA;
              w_op_b_nxt   = E_ALUB;
              w_signed_nxt = (E_ALUControl == OP_MULT);
            end
            OP_DIV, OP_DIVU: begin
              w_state_nxt  = ST_DIV;
              w_cnt_nxt    = CNT_W'(DIV_LAT - 1);
              w_op_a_nxt   = E_ALUA;
              w_op_b_nxt   = E_ALUB;
              w_signed_nxt = (E_ALUControl == OP_DIV);
            end
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
          if (!w_md_div0) begin
            w_hi_nxt = w_md_hi;
            w_lo_nxt = w_md_lo;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_signed <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_op_a   <= w_op_a_nxt;
      r_op_b   <= w_op_b_nxt;
      r_signed <= w_signed_nxt;
    end
  end

endmodule

// File: tb/tb_e_iter_alu.sv
// Self-checking bench for e_iter_alu (default parameters: 32-bit, MUL 5, DIV 10).
// A behavioural model (plain arithmetic, remaining-cycle counter) predicts
// every output each cycle; directed literal checks pin the model itself.
module tb_e_iter_alu;
  import e_iter_alu_pkg::*;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic [3:0]  op;
  logic        st, fl;
  logic [31:0] alure, hi, lo;
  logic        stall, busy;
  logic [4:0]  exc;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state
  logic [31:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;
  logic        m_wr = 1'b0;
  int          m_left = 0;

  always #5 clk = ~clk;

  e_iter_alu dut (
    .clk(clk), .reset(reset), .E_ALUA(a), .E_ALUB(b), .E_ALUControl(op),
    .E_Start(st), .E_Flush(fl), .E_ALURe(alure), .E_Stall(stall),
    .E_Busy(busy), .Cur_E_ExcCode(exc), .E_HI(hi), .E_LO(lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_alu(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      OP_ADDU, OP_ADD: return x + y;
      OP_SUB:  return x - y;
      OP_OR:   return x | y;
      OP_AND:  return x & y;
      OP_SLT:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      OP_SLTU: return (x < y) ? 32'd1 : 32'd0;
      OP_MFHI: return m_hi;
      OP_MFLO: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_ov(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    longint s;
    if (o == OP_ADD)      s = longint'($signed(x)) + longint'($signed(y));
    else if (o == OP_SUB) s = longint'($signed(x)) - longint'($signed(y));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // One clock: drive, check all outputs against the model, advance the model
  task automatic step(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic s, input logic f, input logic r);
    logic        live, ov;
    longint      sa, sb, q, rm;
    logic [63:0] p;
    @(negedge clk);
    op = o; a = x; b = y; st = s; fl = f; reset = r;
    #1;
    live = s && !f;
    ov   = exp_ov(o, x, y);
    if (o <= OP_SLTU || o == OP_NOP || (o <= OP_MFLO && !(live && m_left > 0)))
      chk("alu_result", 64'(alure), 64'(exp_alu(o, x, y)));
    chk("exc_code", 64'(exc), (live && ov) ? 64'h0C : 64'h0);
    chk("busy", 64'(busy), 64'(m_left > 0));
    chk("stall", 64'(stall), 64'(live && m_left > 0 && o >= OP_MFHI && o <= OP_DIVU));
    chk("hi", 64'(hi), 64'(m_hi));
    chk("lo", 64'(lo), 64'(m_lo));
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    if (r) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_wr = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_wr) begin m_hi = m_rhi; m_lo = m_rlo; end
    end else if (live && o >= OP_MTHI && o <= OP_DIVU) begin
      m_wr = 1'b1;
      case (o)
        OP_MTHI: m_hi = x;
        OP_MTLO: m_lo = x;
        OP_MULT: begin p = 64'(sa * sb); {m_rhi, m_rlo} = p; m_left = MUL_LAT; end
        OP_MULTU: begin p = {32'd0, x} * {32'd0, y}; {m_rhi, m_rlo} = p; m_left = MUL_LAT; end
        OP_DIV: begin
          m_left = DIV_LAT;
          m_wr   = (y != 0);
          if (y != 0) begin
            q = sa / sb; rm = sa % sb;
            m_rlo = 32'(q); m_rhi = 32'(rm);
          end
        end
        default: begin // DIVU
          m_left = DIV_LAT;
          m_wr   = (y != 0);
          if (y != 0) begin m_rlo = x / y; m_rhi = x % y; end
        end
      endcase
    end
  endtask

  task automatic idle_until_free(output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      step(OP_NOP, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      if (busy) busy_cycles++;
      else break;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h7FFFFFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nb;
    op = OP_NOP; a = '0; b = '0; st = 1'b0; fl = 1'b0; reset = 1'b1;

    // Reset dominates a presented MULT
    step(OP_MULT, 32'd3, 32'd4, 1'b1, 1'b0, 1'b1);
    step(OP_NOP, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    step(OP_NOP, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);

    // ADD overflow with and without flush
    step(OP_ADD, 32'h7FFFFFFF, 32'd1, 1'b1, 1'b0, 1'b0);
    chk("add_ov_result", 64'(alure), 64'h80000000);
    chk("add_ov_code", 64'(exc), 64'h0C);
    step(OP_ADD, 32'h7FFFFFFF, 32'd1, 1'b1, 1'b1, 1'b0);
    chk("add_ov_flushed", 64'(exc), 64'h0);
    step(OP_SUB, 32'h80000000, 32'd1, 1'b1, 1'b0, 1'b0);
    chk("sub_ov_code", 64'(exc), 64'h0C);
    step(OP_SLT, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0, 1'b0);
    chk("slt_neg", 64'(alure), 64'd1);
    step(OP_SLTU, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0, 1'b0);
    chk("sltu_big", 64'(alure), 64'd0);

    // MULT / MULTU
    step(OP_MULT, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0, 1'b0);
    idle_until_free(nb);
    chk("mult_busy_cycles", 64'(nb), 64'd5);
    chk("mult_hi", 64'(hi), 64'hFFFFFFFF);
    chk("mult_lo", 64'(lo), 64'hFFFFFFFE);
    step(OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0, 1'b0);
    idle_until_free(nb);
    chk("multu_hi", 64'(hi), 64'h1);
    chk("multu_lo", 64'(lo), 64'hFFFFFFFE);

    // DIV cases
    step(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, 1'b0);
    idle_until_free(nb);
    chk("div_busy_cycles", 64'(nb), 64'd10);
    chk("div_lo", 64'(lo), 64'hFFFFFFFD);
    chk("div_hi", 64'(hi), 64'hFFFFFFFF);
    step(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    idle_until_free(nb);
    chk("divmin_lo", 64'(lo), 64'h80000000);
    chk("divmin_hi", 64'(hi), 64'h0);

    // Divide by zero leaves HI/LO alone
    step(OP_MTHI, 32'h12345678, 32'd0, 1'b1, 1'b0, 1'b0);
    step(OP_MTLO, 32'h9ABCDEF0, 32'd0, 1'b1, 1'b0, 1'b0);
    step(OP_DIVU, 32'd55, 32'd0, 1'b1, 1'b0, 1'b0);
    idle_until_free(nb);
    chk("div0_busy_cycles", 64'(nb), 64'd10);
    chk("div0_hi", 64'(hi), 64'h12345678);
    chk("div0_lo", 64'(lo), 64'h9ABCDEF0);

    // MFLO right behind a DIV stalls until the new LO is visible
    step(OP_DIV, 32'd100, 32'd7, 1'b1, 1'b0, 1'b0);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      step(OP_MFLO, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      if (stall) nb++;
      else break;
    end
    chk("mflo_stall_cycles", 64'(nb), 64'd10);
    chk("mflo_after_div", 64'(alure), 64'd14);
    chk("mflo_stall_low", 64'(stall), 64'd0);

    // Reset three cycles into a MULT
    step(OP_MULT, 32'd9, 32'd9, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(OP_NOP, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    step(OP_NOP, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    step(OP_NOP, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_hi", 64'(hi), 64'd0);
    chk("rst_mid_lo", 64'(lo), 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step(4'($urandom_range(0, 15)), pick(), pick(),
           ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 99) < 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
